// File: rtl/seq_alu.sv
// seq_alu: registered, handshaked execute-stage ALU.
//
// Keeps the 6-bit ALU_Control encodings and branch-decision semantics of the
// old combinational ALU. Results and the branch flag are registered and
// delivered through a valid/ready handshake. When SEQ_ALU_MULDIV_EN is
// defined, codes 100000-100111 (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) run
// on an iterative radix-2 engine with a fixed latency of WIDTH+1 edges.
// Without the macro those codes behave as unknown base codes (result 0).
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   in_valid     operation presented
//   in_ready     block can accept an operation this cycle
//   branch_op    instruction is a conditional branch
//   ALU_Control  6-bit operation code
//   operand_A    first operand  (WIDTH)
//   operand_B    second operand (WIDTH)
//   out_valid    ALU_result/branch valid, held until consumed
//   out_ready    consumer takes the result this cycle
//   ALU_result   registered result (WIDTH)
//   branch       registered branch-taken flag
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no operation held; in_ready=1, out_valid=0
// S_CALC | mul/div engine iterating, counter WIDTH-1 down to 0; in_ready=0
// S_DONE | result held on ALU_result/branch; in_ready follows out_ready

module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             branch_op,
  input  logic [5:0]       ALU_Control,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_result,
  output logic             branch
);

`ifdef SEQ_ALU_MULDIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             branch_q, branch_d;
  logic             valid_q, valid_d;

  logic             accept;

  // Base (single-cycle) datapath, evaluated on the live inputs at accept.
  logic [WIDTH-1:0] base_res;
  logic             base_br;
  logic             lt_s, lt_u, eq_ab;
  logic [SHW-1:0]   shamt;

  always_comb begin
    shamt = operand_B[SHW-1:0];
    lt_s  = $signed(operand_A) < $signed(operand_B);
    lt_u  = operand_A < operand_B;
    eq_ab = operand_A == operand_B;

    base_res = '0;
    case (ALU_Control)
      6'b000000:            base_res = operand_A + operand_B;
      6'b001000:            base_res = operand_A - operand_B;
      6'b000010:            base_res = WIDTH'(lt_s);
      6'b000011, 6'b010110: base_res = WIDTH'(lt_u);
      6'b010101:            base_res = WIDTH'(!lt_s);
      6'b010111:            base_res = WIDTH'(!lt_u);
      6'b000110:            base_res = operand_A | operand_B;
      6'b000100:            base_res = operand_A ^ operand_B;
      6'b000111:            base_res = operand_A & operand_B;
      6'b000001:            base_res = operand_A << shamt;
      6'b000101:            base_res = operand_A >> shamt;
      6'b001101:            base_res = $unsigned($signed(operand_A) >>> shamt);
      6'b010000:            base_res = WIDTH'(eq_ab);
      6'b010001:            base_res = WIDTH'(!eq_ab);
      6'b011111, 6'b111111: base_res = operand_A;
      default:              base_res = '0;
    endcase

    base_br = 1'b0;
    if (branch_op) begin
      case (ALU_Control)
        6'b010000: base_br = eq_ab;
        6'b010001: base_br = !eq_ab;
        6'b000010: base_br = lt_s;
        6'b010101: base_br = !lt_s;
        6'b010110: base_br = lt_u;
        6'b010111: base_br = !lt_u;
        default:   base_br = 1'b0;
      endcase
    end
  end

`ifdef SEQ_ALU_MULDIV_EN
  // Engine registers. For multiply hi/lo is the running {product-high,
  // multiplier} pair; for divide hi is the partial remainder and lo shifts
  // the dividend out while the quotient bits shift in.
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [2:0]       op_q, op_d;
  logic             neg_prod_q, neg_prod_d;
  logic             neg_rem_q, neg_rem_d;
  logic             bzero_q, bzero_d;

  logic             is_md;
  logic [2:0]       md_op;
  logic             a_sgn, b_sgn;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rs, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   hi_n, lo_n;
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   quo_c, rem_c;
  logic [WIDTH-1:0]   md_res;

  always_comb begin
    is_md = ALU_Control[5:3] == 3'b100;
    md_op = ALU_Control[2:0];
    // Signed operands: MUL/MULH/DIV/REM both, MULHSU only A.
    a_sgn = ((md_op == 3'b000) || (md_op == 3'b001) || (md_op == 3'b010) ||
             (md_op == 3'b100) || (md_op == 3'b110)) && operand_A[WIDTH-1];
    b_sgn = ((md_op == 3'b000) || (md_op == 3'b001) ||
             (md_op == 3'b100) || (md_op == 3'b110)) && operand_B[WIDTH-1];
    mag_a = a_sgn ? -operand_A : operand_A;
    mag_b = b_sgn ? -operand_B : operand_B;

    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    div_rs   = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_rs - {1'b0, mcand_q};
    // The partial remainder is always below the divisor, so a borrow shows
    // up in the top bit of the (WIDTH+1)-bit difference.
    div_ge   = ~div_diff[WIDTH];

    if (op_q[2]) begin
      hi_n = div_ge ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

    prod_c = neg_prod_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    quo_c  = neg_prod_q ? -lo_n : lo_n;
    rem_c  = neg_rem_q ? -hi_n : hi_n;

    // Divide by zero: the restoring loop already leaves the dividend
    // magnitude as remainder, so only the quotient needs forcing.
    case (op_q)
      3'b000:                 md_res = prod_c[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: md_res = prod_c[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         md_res = bzero_q ? '1 : quo_c;
      default:                md_res = rem_c;
    endcase
  end
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    case (state_q)
      S_IDLE:  in_ready = 1'b1;
      S_DONE:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    branch_d = branch_q;
    valid_d  = valid_q;
`ifdef SEQ_ALU_MULDIV_EN
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mcand_d    = mcand_q;
    op_d       = op_q;
    neg_prod_d = neg_prod_q;
    neg_rem_d  = neg_rem_q;
    bzero_d    = bzero_q;
`endif

    if (accept) begin
`ifdef SEQ_ALU_MULDIV_EN
      if (is_md) begin
        state_d    = S_CALC;
        valid_d    = 1'b0;
        branch_d   = 1'b0;
        cnt_d      = SHW'(WIDTH - 1);
        hi_d       = '0;
        lo_d       = md_op[2] ? mag_a : mag_b;
        mcand_d    = md_op[2] ? mag_b : mag_a;
        op_d       = md_op;
        neg_prod_d = a_sgn ^ b_sgn;
        neg_rem_d  = a_sgn;
        bzero_d    = operand_B == '0;
      end else begin
        state_d  = S_DONE;
        valid_d  = 1'b1;
        result_d = base_res;
        branch_d = base_br;
      end
`else
      state_d  = S_DONE;
      valid_d  = 1'b1;
      result_d = base_res;
      branch_d = base_br;
`endif
    end else if ((state_q == S_DONE) && out_ready) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end
`ifdef SEQ_ALU_MULDIV_EN
    else if (state_q == S_CALC) begin
      hi_d = hi_n;
      lo_d = lo_n;
      if (cnt_q == '0) begin
        state_d  = S_DONE;
        valid_d  = 1'b1;
        result_d = md_res;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      branch_q <= 1'b0;
      valid_q  <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      mcand_q    <= '0;
      op_q       <= '0;
      neg_prod_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      bzero_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      branch_q <= branch_d;
      valid_q  <= valid_d;
`ifdef SEQ_ALU_MULDIV_EN
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mcand_q    <= mcand_d;
      op_q       <= op_d;
      neg_prod_q <= neg_prod_d;
      neg_rem_q  <= neg_rem_d;
      bzero_q    <= bzero_d;
`endif
    end
  end

  assign out_valid  = valid_q;
  assign ALU_result = result_q;
  assign branch     = branch_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        branch_op = 1'b0;
  logic [5:0]  ALU_Control = 6'b000000;
  logic [31:0] operand_A = '0;
  logic [31:0] operand_B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ALU_result;
  logic        branch;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SEQ_ALU_MULDIV_EN
  localparam int LAT_MD = 33;
`else
  localparam int LAT_MD = 1;
`endif

  always #5 clock = ~clock;

  seq_alu #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .branch_op  (branch_op),
    .ALU_Control(ALU_Control),
    .operand_A  (operand_A),
    .operand_B  (operand_B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALU_result (ALU_result),
    .branch     (branch)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait (bounded) for out_valid, check, then consume.
  task automatic run_op(input string tag, input logic [5:0] code,
                        input logic [31:0] a, input logic [31:0] b, input logic bop,
                        input logic [31:0] exp_res, input logic exp_br, input int exp_lat);
    int lat;
    @(negedge clock);
    in_valid = 1'b1; ALU_Control = code; operand_A = a; operand_B = b;
    branch_op = bop; out_ready = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0; ALU_Control = 6'b000000; branch_op = 1'b0;
    operand_A = 32'hA5A5_5A5A; operand_B = 32'h5A5A_A5A5;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, ALU_result, exp_res);
    check({tag, " branch"}, {31'b0, branch}, {31'b0, exp_br});
    @(negedge clock); out_ready = 1'b1;
    @(posedge clock); #1; out_ready = 1'b0;
    check({tag, " drained"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst in_ready", {31'b0, in_ready}, 32'd1);
    check("rst result", ALU_result, 32'd0);
    check("rst branch", {31'b0, branch}, 32'd0);
    reset = 1'b1;

    // Reset while an operation is in flight discards it
    @(negedge clock);
`ifdef SEQ_ALU_MULDIV_EN
    in_valid = 1'b1; ALU_Control = 6'b100011; operand_A = 32'hFFFF_FFFF; operand_B = 32'hFFFF_FFFF;
`else
    in_valid = 1'b1; ALU_Control = 6'b000000; operand_A = 32'd40; operand_B = 32'd2;
`endif
    @(posedge clock); #1; in_valid = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("busy in_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b0; #1;
    check("midrst out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst result", ALU_result, 32'd0);
    @(negedge clock); reset = 1'b1;
    repeat (40) @(negedge clock);
    check("midrst no result", {31'b0, out_valid}, 32'd0);

    // Base operations
    run_op("sub", 6'b001000, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 1'b0, 1);
    run_op("add wrap", 6'b000000, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 1'b0, 1);
    run_op("blt", 6'b000010, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1, 1'b1, 1);
    run_op("bltu", 6'b010110, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 1'b0, 1);
    run_op("blt nobr", 6'b000010, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1, 1'b0, 1);
    run_op("beq", 6'b010000, 32'h1234, 32'h1234, 1'b1, 32'd1, 1'b1, 1);
    run_op("bne", 6'b010001, 32'h1234, 32'h1234, 1'b1, 32'd0, 1'b0, 1);
    run_op("bge", 6'b010101, 32'd3, 32'hFFFF_FFFF, 1'b1, 32'd1, 1'b1, 1);
    run_op("bgeu", 6'b010111, 32'd3, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0, 1);
    run_op("sltu", 6'b000011, 32'd1, 32'd2, 1'b1, 32'd1, 1'b0, 1);
    run_op("sra", 6'b001101, 32'h8000_0000, 32'h0000_0024, 1'b0, 32'hF800_0000, 1'b0, 1);
    run_op("sll", 6'b000001, 32'd1, 32'd31, 1'b0, 32'h8000_0000, 1'b0, 1);
    run_op("srl", 6'b000101, 32'h8000_0000, 32'h0000_0021, 1'b0, 32'h4000_0000, 1'b0, 1);
    run_op("or", 6'b000110, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0, 32'hF0F0_0F0F, 1'b0, 1);
    run_op("and", 6'b000111, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 32'h0F00_0F00, 1'b0, 1);
    run_op("passa", 6'b111111, 32'hCAFE_F00D, 32'd9, 1'b1, 32'hCAFE_F00D, 1'b0, 1);
    run_op("unknown", 6'b001001, 32'd7, 32'd9, 1'b1, 32'd0, 1'b0, 1);

    // Multi-cycle codes
`ifdef SEQ_ALU_MULDIV_EN
    run_op("mulh", 6'b100001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0, LAT_MD);
    run_op("mulhu", 6'b100011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, LAT_MD);
    run_op("mul", 6'b100000, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB, 1'b0, LAT_MD);
    run_op("mulhsu", 6'b100010, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'hFFFF_FFFF, 1'b0, LAT_MD);
    run_op("div ovf", 6'b100100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0, LAT_MD);
    run_op("rem ovf", 6'b100110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0, LAT_MD);
    run_op("divu0", 6'b100101, 32'd12345, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, LAT_MD);
    run_op("remu0", 6'b100111, 32'd9, 32'd0, 1'b0, 32'd9, 1'b0, LAT_MD);
    run_op("div0 neg", 6'b100100, 32'hFFFF_FFF9, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, LAT_MD);
    run_op("div", 6'b100100, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 1'b0, LAT_MD);
    run_op("rem", 6'b100110, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 1'b0, LAT_MD);
    run_op("divu", 6'b100101, 32'd100, 32'd7, 1'b0, 32'd14, 1'b0, LAT_MD);
`else
    run_op("mul off", 6'b100000, 32'd7, 32'd3, 1'b1, 32'd0, 1'b0, LAT_MD);
    run_op("div off", 6'b100100, 32'd100, 32'd7, 1'b0, 32'd0, 1'b0, LAT_MD);
`endif

    // Backpressure then back-to-back
    @(negedge clock);
    in_valid = 1'b1; ALU_Control = 6'b000100; operand_A = 32'hF0F0_F0F0; operand_B = 32'h0FF0_0FF0;
    branch_op = 1'b0; out_ready = 1'b0;
    @(posedge clock); #1; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("hold valid", {31'b0, out_valid}, 32'd1);
      check("hold result", ALU_result, 32'hFF00_FF00);
      check("hold in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1; in_valid = 1'b1; ALU_Control = 6'b000000;
    operand_A = 32'd2; operand_B = 32'd3; #1;
    check("done in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clock); #1;
    check("b2b add valid", {31'b0, out_valid}, 32'd1);
    check("b2b add result", ALU_result, 32'd5);
    ALU_Control = 6'b001000; operand_A = 32'd10; operand_B = 32'd4;
    @(posedge clock); #1;
    check("b2b sub valid", {31'b0, out_valid}, 32'd1);
    check("b2b sub result", ALU_result, 32'd6);
    in_valid = 1'b0;
    @(posedge clock); #1;
    check("b2b idle", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the single-cycle combinational ALU in the execute stage. It keeps the existing 6-bit `ALU_Control` encodings and branch-decision semantics, but registers results and generalises the datapath width. It also adds multi-cycle RV32M-style multiply/divide/remainder through an iterative radix-2 engine. The block sits between decode and writeback, and stalls the pipeline through a valid/ready handshake.

## Interface
- `WIDTH`, 32: operand/result width; must be ≥ 8 and a power of two.
- `SHW`, $clog2(WIDTH): shift-amount width (derived; do not override).
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  block can accept an operation this cycle.
- `branch_op`  in  1  instruction is a conditional branch.
- `ALU_Control`  in  6  operation code.
- `operand_A`  in  WIDTH  first operand.
- `operand_B`  in  WIDTH  second operand.
- `out_valid`  out  1  `ALU_result`/`branch` valid; held until consumed.
- `out_ready`  in  1  consumer takes the result this cycle.
- `ALU_result`  out  WIDTH  registered result.
- `branch`  out  1  registered branch-taken flag.

## Operation
- **Accept:** an operation is accepted when `in_valid && in_ready` on a rising edge. Operands, code and `branch_op` are captured internally, so inputs may change afterwards.
- **Base codes** (single-cycle class):
  - `000000` add; `001000` sub.
  - `000010` signed less-than; `000011`/`010110` unsigned less-than; `010101` signed ≥; `010111` unsigned ≥.
  - `000110` or; `000100` xor; `000111` and.
  - `000001` sll; `000101` srl; `001101` sra.
  - `010000` equal; `010001` not-equal.
  - `011111`/`111111` pass `operand_A`.
  - Any other code → 0.
- **Compares:** results are zero-extended to WIDTH (value 0 or 1).
- **Shifts:** use `operand_B[SHW-1:0]` only; upper bits are ignored. `sra` replicates `operand_A[WIDTH-1]`.
- **Branch flag:** when `branch_op`=0, `branch`=0. Otherwise `branch`=1 iff the code is one of `010000`, `010001`, `000010`, `010101`, `010110`, `010111` and the corresponding comparison is true. All other codes give 0.
- **Multi-cycle codes:**
  - `100000` MUL: low WIDTH bits of the product.
  - `100001` MULH: signed×signed, high half.
  - `100010` MULHSU: signed A × unsigned B, high half.
  - `100011` MULHU: unsigned×unsigned, high half.
  - `100100` DIV; `100101` DIVU; `100110` REM; `100111` REMU.
  - `branch`=0 for all of them.
- **Engine:** operands are converted to magnitudes at accept. The engine runs WIDTH shift-add (multiply) or restoring shift-subtract (divide) iterations, then applies the sign correction when loading `ALU_result`.
- **Divide by zero:** quotient = all ones; remainder = dividend (unsigned and signed alike).
- **Signed overflow** (DIV/REM with A = most-negative, B = −1): quotient = A; remainder = 0.
- **States:**
  - IDLE (`in_ready`=1, `out_valid`=0).
  - CALC (iteration counter WIDTH−1 down to 0; `in_ready`=0).
  - DONE (`out_valid`=1).
- **Transitions:**
  - IDLE→DONE on accepting a base code.
  - IDLE→CALC on accepting a multi-cycle code.
  - CALC→DONE when the counter reaches 0.
  - DONE→IDLE on `out_ready` with no new accept.
  - DONE→DONE/CALC on `out_ready && in_valid`. In DONE, `in_ready` = `out_ready`, which allows back-to-back operations.
- **Output hold:** in DONE without `out_ready`, `ALU_result` and `branch` hold stable.

## Timing
- **Reset values:** while `reset`=0 the state is IDLE, `out_valid`=0, `in_ready`=1, `ALU_result`=0, `branch`=0 and the counter is 0. Reset during CALC or DONE discards the operation without producing a result.
- **Base-code latency:** `out_valid` rises on the edge after accept (1 cycle).
- **Multi-cycle latency:** `out_valid` rises WIDTH+1 edges after accept (33 for WIDTH=32). Latency is fixed and independent of operand values.
- **Throughput:** one base operation per cycle when `out_ready` is held at 1.
- **Combinational paths:** `in_ready` depends combinationally on `out_ready` only in DONE. No other input→output path is combinational.

## Configuration
- **`SEQ_ALU_MULDIV_EN` defined:** the multi-cycle engine and codes `100000`–`100111` are present as described above.
- **`SEQ_ALU_MULDIV_EN` undefined:** the engine and CALC state are removed. Codes `100000`–`100111` behave as unknown base codes: result 0, `branch`=0, 1-cycle latency.

## Test plan
- **Reset and sub:** reset low mid-CALC, then release; expect `out_valid`=0 and `in_ready`=1. Then SUB A=5, B=7 → `ALU_result`=0xFFFFFFFE one cycle later.
- **Branches:** BLT (`000010`) with `branch_op`=1, A=0xFFFFFFFF, B=1 → `branch`=1. BLTU (`010110`) with the same operands → `branch`=0. Any code with `branch_op`=0 → `branch`=0.
- **Shift masking:** SRA A=0x80000000, B=0x00000024 (amount masked to 4) → 0xF8000000. SLL A=1, B=31 → 0x80000000.
- **Multiply** (`SEQ_ALU_MULDIV_EN`): MULH A=0xFFFFFFFF, B=0xFFFFFFFF → 0. MULHU with the same operands → 0xFFFFFFFE, `out_valid` exactly 33 cycles after accept. MUL 7×−3 → 0xFFFFFFEB.
- **Divide edge cases:** DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM with the same operands → 0. DIVU x/0 → 0xFFFFFFFF. REMU 9/0 → 9. DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE; result stays stable and `in_ready`=0. Then `out_ready`=1 with `in_valid`=1 and ADD 2+3 → result 5 on the next cycle with no bubble.
